// File: rtl/priv_1_12_hpm_counters.sv
// Machine/user hardware performance counters: mcycle, minstret, mhpmcounter3+, inhibit, enable and event select.
// Reads and the illegal-access flag are combinational; counter, CSR and overflow state update on the rising CLK edge.
module priv_1_12_hpm_counters #(
  parameter int NUM_HPM    = 4,
  parameter int CTR_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [11:0]           csr_addr,
  input  logic [1:0]            curr_priv,
  input  logic                  csr_write,
  input  logic                  csr_set,
  input  logic                  csr_clear,
  input  logic [31:0]           new_csr_val,
  input  logic                  inst_ret,
  input  logic [NUM_EVENTS-1:0] events,
  output logic [31:0]           old_csr_val,
  output logic                  invalid_csr,
  output logic [NUM_HPM-1:0]    ctr_overflow
);

  typedef logic [CTR_WIDTH-1:0] ctr_t;

  // Implemented bits of mcountinhibit / mcounteren: CY, IR and one per hpm counter.
  localparam logic [31:0] CNT_MASK = 32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

  ctr_t                             mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [NUM_HPM-1:0][CTR_WIDTH-1:0] hpm_q, hpm_d;
  logic [NUM_HPM-1:0][5:0]          ev_q, ev_d;
  logic [31:0]                      inhibit_q, inhibit_d, counteren_q, counteren_d;
  logic [NUM_HPM-1:0]               ovf_q, ovf_d;

  logic [4:0]         idx;
  logic               strobe, is_m, idx_ok, hpm_ok;
  logic               is_ctr_m, is_ctr_u, is_evt, is_inh, is_en, do_mod;
  logic [63:0]        ctr_sel, ctr_mod, evp;
  logic [31:0]        ev_sel, rdata, mod_val;
  logic [NUM_HPM-1:0] hpm_inc;

  always_comb begin
    idx      = csr_addr[4:0];
    strobe   = csr_write | csr_set | csr_clear;
    is_m     = (curr_priv == 2'b11);
    hpm_ok   = (32'(idx) >= 3) && (32'(idx) < 3 + NUM_HPM);
    idx_ok   = (idx == 5'd0) || (idx == 5'd2) || hpm_ok;
    is_ctr_m = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00) && idx_ok;
    is_ctr_u = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00) && idx_ok;
    is_evt   = (csr_addr[11:5] == 7'b0011001) && hpm_ok;
    is_inh   = (csr_addr == 12'h320);
    is_en    = (csr_addr == 12'h306);

    ctr_sel = '0;
    ev_sel  = '0;
    if (idx == 5'd0) ctr_sel = 64'(mcycle_q);
    if (idx == 5'd2) ctr_sel = 64'(minstret_q);
    for (int i = 0; i < NUM_HPM; i++) begin
      if (32'(idx) == 3 + i) begin
        ctr_sel = 64'(hpm_q[i]);
        ev_sel  = 32'(ev_q[i]);
      end
    end

    if (is_inh)      rdata = inhibit_q;
    else if (is_en)  rdata = counteren_q;
    else if (is_evt) rdata = ev_sel;
    else             rdata = csr_addr[7] ? ctr_sel[63:32] : ctr_sel[31:0];

    // Shadows are never writable; read access needs M or the matching mcounteren bit.
    invalid_csr = !(is_ctr_m || is_ctr_u || is_evt || is_inh || is_en)
               || (!is_ctr_u && !is_m)
               || (is_ctr_u && !is_m && !counteren_q[idx])
               || (is_ctr_u && strobe);
    old_csr_val = invalid_csr ? 32'h0 : rdata;

    if (csr_write)    mod_val = new_csr_val;
    else if (csr_set) mod_val = rdata | new_csr_val;
    else              mod_val = rdata & ~new_csr_val;
    ctr_mod = csr_addr[7] ? {mod_val, ctr_sel[31:0]} : {ctr_sel[63:32], mod_val};
    do_mod  = strobe && !invalid_csr;
  end

  always_comb begin
    evp                   = '0;
    evp[NUM_EVENTS:1]     = events;
    mcycle_d    = mcycle_q + ctr_t'(!inhibit_q[0]);
    minstret_d  = minstret_q + ctr_t'(inst_ret && !inhibit_q[2]);
    ev_d        = ev_q;
    inhibit_d   = inhibit_q;
    counteren_d = counteren_q;
    hpm_inc     = '0;
    hpm_d       = hpm_q;
    ovf_d       = '0;
    for (int i = 0; i < NUM_HPM; i++) begin
      hpm_inc[i] = evp[ev_q[i]] && !inhibit_q[3+i];
      hpm_d[i]   = hpm_q[i] + ctr_t'(hpm_inc[i]);
      ovf_d[i]   = hpm_inc[i] && (&hpm_q[i]);
    end

    if (do_mod) begin
      // A modified counter takes the new value and skips this cycle's increment.
      if (is_ctr_m) begin
        if (idx == 5'd0) mcycle_d   = ctr_t'(ctr_mod);
        if (idx == 5'd2) minstret_d = ctr_t'(ctr_mod);
        for (int i = 0; i < NUM_HPM; i++) begin
          if (32'(idx) == 3 + i) begin
            hpm_d[i] = ctr_t'(ctr_mod);
            ovf_d[i] = 1'b0;
          end
        end
      end
      if (is_inh) inhibit_d   = mod_val & CNT_MASK;
      if (is_en)  counteren_d = mod_val & CNT_MASK;
      if (is_evt) begin
        for (int i = 0; i < NUM_HPM; i++) begin
          if (32'(idx) == 3 + i)
            ev_d[i] = (mod_val >= 32'd1 && mod_val <= 32'(NUM_EVENTS)) ? 6'(mod_val) : 6'd0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mcycle_q    <= '0;
      minstret_q  <= '0;
      hpm_q       <= '0;
      ev_q        <= '0;
      inhibit_q   <= '0;
      counteren_q <= '0;
      ovf_q       <= '0;
    end else begin
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      hpm_q       <= hpm_d;
      ev_q        <= ev_d;
      inhibit_q   <= inhibit_d;
      counteren_q <= counteren_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ctr_overflow = ovf_q;

endmodule
